// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types for the instruction/data memory arbiter: FSM state
//           encoding, grant identifier and counter sizing helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2,
      RESP  = 2'd3
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   // Width needed to hold values 0..timeout; at least one bit so a disabled
   // timeout (0) still yields a legal vector.
   function automatic int cnt_width(input int timeout);
      return (timeout < 2) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Arbitrates an instruction-fetch port and a data load/store port
//           onto one shared memory port. Alternating priority on conflicts,
//           registered memory strobes, optional busy timeout with err pulse.
// Ports   : clk, rst_n           - clock, async active-low reset
//           i_req/i_addr         - fetch request (held until i_ready)
//           i_rdata/i_ready      - fetch data and completion pulse
//           d_read/d_write/d_addr/d_wdata - data request (held until d_ready)
//           d_rdata/d_ready      - load data and completion pulse
//           mem_read/mem_write/mem_addr/mem_wdata - shared port request
//           mem_rdata/mem_ready  - shared port response
//           err                  - timeout abort flag, coincident with ready
//           stall_if/stall_mem   - pipeline stall requests
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              err,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int              CNT_W     = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   state_t              state_q,      state_d;
   grant_t              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q,        cnt_d;
   logic                mem_read_q,   mem_read_d;
   logic                mem_write_q,  mem_write_d;
   logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
   logic                i_ready_q,    i_ready_d;
   logic                d_ready_q,    d_ready_d;
   logic                err_q,        err_d;
   logic [DATA_W-1:0]   i_rdata_q,    i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;

   logic                d_pend;
   logic                grant_d_w;
   logic                grant_i_w;
   logic [CNT_W-1:0]    cnt_inc;
   logic                timeout_hit;

   // Data wins when fetch is idle or fetch was served last; otherwise fetch.
   assign d_pend      = d_read | d_write;
   assign grant_d_w   = d_pend & (~i_req | (last_grant_q == GRANT_I));
   assign grant_i_w   = ~grant_d_w & i_req;
   // cnt_inc is the number of busy cycles including the current one.
   assign cnt_inc     = cnt_q + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_LIMIT);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
         cnt_q        <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         err_q        <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         err_q        <= err_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (grant_d_w) begin
               state_d      = DBUSY;
               last_grant_d = GRANT_D;
            end else if (grant_i_w) begin
               state_d      = IBUSY;
               last_grant_d = GRANT_I;
            end
         end
         IBUSY, DBUSY: begin
            if (mem_ready || timeout_hit) begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------- output logic
   always_comb begin
      cnt_d       = cnt_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            // Latch the winning request; the port holds it for the whole
            // busy phase. Read+write together is treated as a store.
            if (grant_d_w) begin
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_write_d = d_write;
               mem_read_d  = ~d_write;
            end else if (grant_i_w) begin
               mem_addr_d  = i_addr;
               mem_wdata_d = '0;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
            end
         end
         IBUSY, DBUSY: begin
            cnt_d = cnt_inc;
            if (mem_ready || timeout_hit) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               err_d       = ~mem_ready;
               if (state_q == IBUSY) begin
                  i_ready_d = 1'b1;
                  if (mem_ready) i_rdata_d = mem_rdata;
               end else begin
                  d_ready_d = 1'b1;
                  // Stores and aborted loads leave d_rdata untouched.
                  if (mem_ready && !mem_write_q) d_rdata_d = mem_rdata;
               end
            end
         end
         default: ;
      endcase
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;
   assign err       = err_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign stall_if  = i_req & ~i_ready_q;
   assign stall_mem = d_pend & ~d_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Randomized self-checking bench for mem_arbiter with a behavioural
//           transaction model (owner / age / last-served bookkeeping).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_read = 1'b0;
   logic          d_write = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          err;
   logic          stall_if;
   logic          stall_mem;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .err(err), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
   endtask

   // ------------------------------------------------------ reference model
   // m_phase: 0 waiting for a request, 1 transfer in progress, 2 reply cycle
   int            m_phase;
   int            m_owner;   // 0 fetch, 1 data
   int            m_age;     // busy cycles already spent
   int            m_last;    // 0 fetch served last, 1 data served last
   logic          e_mem_read, e_mem_write, e_i_ready, e_d_ready, e_err;
   logic [AW-1:0] e_mem_addr;
   logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;

   task automatic m_reset();
      m_phase = 0; m_owner = 0; m_age = 0; m_last = 0;
      e_mem_read = 0; e_mem_write = 0; e_i_ready = 0; e_d_ready = 0; e_err = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0;
   endtask

   // Advance the model over one rising edge using the inputs now applied.
   task automatic m_step();
      e_i_ready = 0; e_d_ready = 0; e_err = 0;
      if (m_phase == 0) begin
         if ((d_read || d_write) && (!i_req || m_last == 0)) begin
            m_owner = 1; m_last = 1; m_phase = 1; m_age = 0;
            e_mem_addr = d_addr; e_mem_wdata = d_wdata;
            e_mem_write = d_write; e_mem_read = !d_write;
         end else if (i_req) begin
            m_owner = 0; m_last = 0; m_phase = 1; m_age = 0;
            e_mem_addr = i_addr; e_mem_wdata = '0;
            e_mem_write = 0; e_mem_read = 1;
         end
      end else if (m_phase == 1) begin
         if (mem_ready || (m_age + 1 == TO)) begin
            if (mem_ready) begin
               if (m_owner == 0) e_i_rdata = mem_rdata;
               else if (!e_mem_write) e_d_rdata = mem_rdata;
            end else begin
               e_err = 1;
            end
            if (m_owner == 0) e_i_ready = 1; else e_d_ready = 1;
            e_mem_read = 0; e_mem_write = 0; m_phase = 2;
         end else begin
            m_age++;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   // ------------------------------------------------------ requesters
   bit i_act = 0;
   bit d_act = 0;
   int d_kind = 0;   // 0 load, 1 store, 2 both strobes (store)

   task automatic run_cycle(input int i_pct, input int d_pct, input int rdy_pct);
      @(negedge clk);
      check("i_ready",   i_ready,   e_i_ready);
      check("d_ready",   d_ready,   e_d_ready);
      check("err",       err,       e_err);
      check("i_rdata",   i_rdata,   e_i_rdata);
      check("d_rdata",   d_rdata,   e_d_rdata);
      check("mem_read",  mem_read,  e_mem_read);
      check("mem_write", mem_write, e_mem_write);
      check("mem_addr",  mem_addr,  e_mem_addr);
      check("mem_wdata", mem_wdata, e_mem_wdata);
      if (i_act && e_i_ready) i_act = 0;
      if (d_act && e_d_ready) d_act = 0;
      if (!i_act && $urandom_range(0, 99) < i_pct) begin
         i_act = 1; i_addr = AW'($urandom);
      end
      if (!d_act && $urandom_range(0, 99) < d_pct) begin
         d_act = 1; d_kind = int'($urandom_range(0, 2));
         d_addr = AW'($urandom); d_wdata = $urandom;
      end
      i_req     = i_act;
      d_read    = d_act && (d_kind != 1);
      d_write   = d_act && (d_kind != 0);
      mem_ready = ($urandom_range(0, 99) < rdy_pct);
      mem_rdata = $urandom;
      #1;
      check("stall_if",  stall_if,  i_req & ~e_i_ready);
      check("stall_mem", stall_mem, (d_read | d_write) & ~e_d_ready);
      m_step();
   endtask

   initial begin
      m_reset();
      rst_n = 0;
      repeat (2) @(negedge clk);
      check("rst_i_rdata",  i_rdata,  0);
      check("rst_d_rdata",  d_rdata,  0);
      check("rst_i_ready",  i_ready,  0);
      check("rst_d_ready",  d_ready,  0);
      check("rst_err",      err,      0);
      check("rst_mem_rd",   mem_read, 0);
      check("rst_mem_wr",   mem_write, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_stall",    {stall_if, stall_mem}, 0);
      rst_n = 1;

      // Fast memory first, then a slow memory that frequently times out.
      for (int k = 0; k < 1500; k++) run_cycle(40, 40, (k < 750) ? 50 : 12);
      repeat (20) run_cycle(0, 0, 50);

      // Reset in the middle of a data transfer.
      run_cycle(0, 100, 0);
      run_cycle(0, 0, 0);
      @(posedge clk);
      #2;
      check("pre_rst_busy", mem_read | mem_write, 1);
      rst_n = 0;
      #1;
      check("mid_rst_mem_rd",   mem_read,  0);
      check("mid_rst_mem_wr",   mem_write, 0);
      check("mid_rst_mem_addr", mem_addr,  0);
      check("mid_rst_mem_wd",   mem_wdata, 0);
      check("mid_rst_i_rdata",  i_rdata,   0);
      check("mid_rst_d_rdata",  d_rdata,   0);
      check("mid_rst_readys",   {i_ready, d_ready, err}, 0);
      i_act = 0; d_act = 0;
      i_req = 0; d_read = 0; d_write = 0;
      mem_ready = 1;
      m_reset();
      @(negedge clk);
      rst_n = 1;
      repeat (5) run_cycle(0, 0, 100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
